data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32: CPU and memory data width.
REQ-002 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 Parameter NUM_LINES, default 64: direct-mapped lines, power of two.
REQ-004 Parameter WORDS_PER_LINE, default 4: words per line, power of two.
REQ-005 Port list SHALL be:
- clk, input, 1: single clock, all state updates on rising edge.
- reset, input, 1: synchronous, active-high.
- A, input, ADDR_WIDTH: byte address from memory stage.
- WD, input, DATA_WIDTH: store data, already lane-aligned by the memory stage.
- WE, input, 1: store request.
- RE, input, 1: load request.
- RD, output, DATA_WIDTH: load data.
- stall, output, 1: holds the requesting pipeline stage.
- mem_req, output, 1: backing-memory request valid.
- mem_we, output, 1: backing-memory write.
- mem_addr, output, ADDR_WIDTH: word-aligned backing-memory address.
- mem_wdata, output, DATA_WIDTH: backing-memory write data.
- mem_ack, input, 1: backing memory accepted the request, with read data valid this cycle.
- mem_rdata, input, DATA_WIDTH: backing-memory read data.

Function
REQ-006 Address split: offset A[log2(WORDS_PER_LINE)+1:2], index next log2(NUM_LINES) bits, tag the remaining upper bits; A[1:0] ignored.
REQ-007 FSM states: IDLE, REFILL, WRITE.
REQ-008 IDLE, RE=1, WE=0, hit (valid and tag match):
- RD = cached word, combinational.
- stall=0.
- No state change.
REQ-009 IDLE, RE=1, miss: stall=1 combinationally; next state REFILL; refill word counter cleared to 0.
REQ-010 REFILL: mem_req=1, mem_we=0, mem_addr = {tag,index,counter,2'b00}, stall=1.
REQ-011 REFILL, each cycle with mem_ack=1: write mem_rdata into the line word selected by the counter; increment the counter.
REQ-012 REFILL, mem_ack on the last word: set line valid, write tag, next state IDLE. The load then hits one cycle later, so miss latency = WORDS_PER_LINE ack cycles + 1.
REQ-013 IDLE, WE=1: stall=1 combinationally; WD and A captured into write registers; next state WRITE. WE=1 with RE=1 is treated as a write.
REQ-014 WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata taken from the write registers.
REQ-015 WRITE, mem_ack=0: stall=1.
REQ-016 WRITE, mem_ack=1:
- stall=0, releasing the pipeline that cycle.
- If the line is valid with a matching tag, the cached word is updated with the store data.
- Next state IDLE.
- Write policy: write-through, no-write-allocate; a miss leaves the line untouched.
REQ-017 IDLE, RE=0, WE=0: stall=0, mem_req=0; RD = cached word at A regardless of hit.
REQ-018 mem_ack with mem_req=0 SHALL be ignored.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable from request until mem_ack.
REQ-020 mem_req SHALL be 0 in IDLE.

Reset
REQ-021 reset=1 at a clock edge: state IDLE, all valid bits 0, refill counter 0, write registers 0.
REQ-022 While in IDLE after reset: stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 Reset mid-REFILL: abort; the partially filled line remains invalid; mem_req=0 from the next cycle.
REQ-024 Reset mid-WRITE: abort; no cache update.
REQ-025 Tag and data arrays are not required to be cleared by reset.

Structure
REQ-026 Package cache_pkg SHALL hold:
- the state enum (IDLE/REFILL/WRITE);
- default geometry constants;
- derived offset/index/tag widths.
REQ-027 One sub-module, cache_line_array, SHALL hold:
- valid, tag and data storage;
- combinational read by index/offset;
- synchronous single-word write;
- valid set/clear.
REQ-028 data_cache SHALL contain only the FSM, counter, write registers and hit logic.

Verification
REQ-029 After reset, RE=1, A=0x100; memory returns 0xA0..0xA3 with one ack per cycle -> stall high 5 cycles, then RD=0xA0 with stall=0; mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
REQ-030 Following REQ-029, RE=1, A=0x108 -> same-cycle hit, RD=0xA2, stall=0, mem_req=0.
REQ-031 WE=1, A=0x104, WD=0xDEADBEEF, mem_ack delayed 3 cycles -> stall high until the ack cycle, single memory write to 0x104; a subsequent read of 0x104 hits with RD=0xDEADBEEF.
REQ-032 WE=1, A=0x2000 (miss) -> memory write issued; a subsequent read of 0x2000 misses and triggers a refill.
REQ-033 Aliasing: read 0x100, then read 0x500 (same index, different tag) -> second read refills and evicts; re-reading 0x100 misses again.
REQ-034 reset asserted after the 2nd refill ack of a miss to 0x300 -> mem_req=0 next cycle; re-reading 0x300 performs a full 4-word refill.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_NUM_LINES      = 64;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int DEF_OFF_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int DEF_IDX_W = $clog2(DEF_NUM_LINES);
  localparam int DEF_TAG_W = DEF_ADDR_WIDTH - DEF_IDX_W - DEF_OFF_W - 2;

  // Tag bits left after removing the byte lane, word offset and line index.
  function automatic int tag_width(input int addr_width, input int num_lines,
                                   input int words_per_line);
    return addr_width - $clog2(num_lines) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the data cache: combinational read, single-word
// synchronous write, per-line valid set on fill completion and clear on invalidate.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int TAG_W          = DEF_TAG_W,
  localparam int IDX_W         = $clog2(NUM_LINES),
  localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_index,
  input  logic [OFF_W-1:0]      rd_offset,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_word,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [OFF_W-1:0]      wr_offset,
  input  logic [DATA_WIDTH-1:0] wr_word,
  input  logic                  fill_done,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic                  inval_en,
  input  logic [IDX_W-1:0]      inval_index
);

  logic                  valid_reg [NUM_LINES];
  logic [TAG_W-1:0]      tag_mem   [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem  [NUM_LINES*WORDS_PER_LINE];

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_done && wr_index == IDX_W'(gi)) begin
          valid_reg[gi] <= 1'b1;
        end else if (inval_en && inval_index == IDX_W'(gi)) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_offset}] <= wr_word;
    end
    if (fill_done) begin
      tag_mem[wr_index] <= fill_tag;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a blocking
// refill/write FSM in front of a single-request backing memory.
module data_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  WE,
  input  logic                  RE,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = tag_width(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_W = TAG_W + IDX_W;
  localparam int WORD_W = ADDR_WIDTH - 2;

  state_t            state_reg;
  logic [OFF_W-1:0]  cnt_reg;
  logic [LINE_W-1:0] line_reg;
  logic [WORD_W-1:0] wr_word_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic              wr_hit_reg;

  logic [OFF_W-1:0] a_off;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;
  logic             unused_lane;

  assign a_off       = A[OFF_W+1:2];
  assign a_idx       = A[IDX_W+OFF_W+1:OFF_W+2];
  assign a_tag       = A[ADDR_WIDTH-1:ADDR_WIDTH-TAG_W];
  assign unused_lane = ^A[1:0];

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  hit;
  logic                  miss;
  logic                  last_word;

  assign hit       = rd_valid && (rd_tag == a_tag);
  assign miss      = RE && !WE && !hit;
  assign last_word = (cnt_reg == OFF_W'(WORDS_PER_LINE - 1));
  assign RD        = rd_word;

  logic                  arr_we;
  logic [IDX_W-1:0]      arr_idx;
  logic [OFF_W-1:0]      arr_off;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  fill_done;
  logic                  inval_en;

  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_idx   = line_reg[IDX_W-1:0];
    arr_off   = cnt_reg;
    arr_wdata = mem_rdata;
    fill_done = 1'b0;
    inval_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        stall    = WE || miss;
        // The line is about to be overwritten word by word, so it must not
        // look valid if the refill is cut short.
        inval_en = miss && !reset;
      end
      REFILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {line_reg, cnt_reg, 2'b00};
        arr_we    = mem_ack && !reset;
        fill_done = mem_ack && last_word && !reset;
      end
      WRITE: begin
        stall     = !mem_ack;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wr_word_reg, 2'b00};
        mem_wdata = wr_data_reg;
        arr_idx   = wr_word_reg[OFF_W+IDX_W-1:OFF_W];
        arr_off   = wr_word_reg[OFF_W-1:0];
        arr_wdata = wr_data_reg;
        arr_we    = mem_ack && wr_hit_reg && !reset;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      line_reg    <= '0;
      wr_word_reg <= '0;
      wr_data_reg <= '0;
      wr_hit_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (WE) begin
            // Hit status is frozen here; nothing else touches the cache until the write retires.
            wr_word_reg <= A[ADDR_WIDTH-1:2];
            wr_data_reg <= WD;
            wr_hit_reg  <= hit;
            state_reg   <= WRITE;
          end else if (miss) begin
            line_reg  <= A[ADDR_WIDTH-1:OFF_W+2];
            cnt_reg   <= '0;
            state_reg <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt_reg <= cnt_reg + OFF_W'(1);
            if (last_word) begin
              state_reg <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  cache_line_array #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_lines (
    .clk         (clk),
    .reset       (reset),
    .rd_index    (a_idx),
    .rd_offset   (a_off),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_word     (rd_word),
    .wr_en       (arr_we),
    .wr_index    (arr_idx),
    .wr_offset   (arr_off),
    .wr_word     (arr_wdata),
    .fill_done   (fill_done),
    .fill_tag    (line_reg[LINE_W-1:IDX_W]),
    .inval_en    (inval_en),
    .inval_index (a_idx)
  );

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: refill, hit, write-through, no-write-allocate,
// aliasing and reset-abort scenarios against a small backing-memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic        RE;
  logic [31:0] RD;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] bmem [int unsigned];

  always #5 clk = ~clk;

  data_cache dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .WD        (WD),
    .WE        (WE),
    .RE        (RE),
    .RD        (RD),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] base, input logic [31:0] seed);
    for (int k = 0; k < 4; k++) begin
      bmem[(base >> 2) + k] = seed + k;
    end
  endtask

  task automatic read_miss(input logic [31:0] addr);
    logic [31:0] base;
    int stalls;
    base = {addr[31:4], 4'b0000};
    stalls = 0;
    step();
    RE = 1'b1; WE = 1'b0; A = addr;
    settle();
    chk("miss_stall_idle", stall, 1);
    chk("miss_req_idle", mem_req, 0);
    if (stall) stalls++;
    for (int k = 0; k < 4; k++) begin
      step();
      mem_ack = 1'b1;
      mem_rdata = bmem[(base >> 2) + k];
      settle();
      chk("refill_req", mem_req, 1);
      chk("refill_we", mem_we, 0);
      chk("refill_addr", mem_addr, base + 32'(4 * k));
      if (stall) stalls++;
    end
    step();
    mem_ack = 1'b0;
    mem_rdata = '0;
    settle();
    if (stall) stalls++;
    chk("miss_stall_cycles", 32'(stalls), 5);
    chk("miss_rd", RD, bmem[addr >> 2]);
    $display("read miss  A=0x%08h RD=0x%08h stall_cycles=%0d", addr, RD, stalls);
  endtask

  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
    step();
    RE = 1'b1; WE = 1'b0; A = addr;
    settle();
    chk("hit_stall", stall, 0);
    chk("hit_req", mem_req, 0);
    chk("hit_rd", RD, exp);
    $display("read hit   A=0x%08h RD=0x%08h", addr, RD);
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data, input int delay);
    int writes;
    writes = 0;
    step();
    RE = 1'b0; WE = 1'b1; A = addr; WD = data;
    settle();
    chk("wr_stall_idle", stall, 1);
    chk("wr_req_idle", mem_req, 0);
    for (int d = 0; d < delay; d++) begin
      step();
      settle();
      chk("wr_wait_req", mem_req, 1);
      chk("wr_wait_we", mem_we, 1);
      chk("wr_wait_addr", mem_addr, {addr[31:2], 2'b00});
      chk("wr_wait_data", mem_wdata, data);
      chk("wr_wait_stall", stall, 1);
    end
    step();
    mem_ack = 1'b1;
    settle();
    chk("wr_ack_stall", stall, 0);
    chk("wr_ack_addr", mem_addr, {addr[31:2], 2'b00});
    if (mem_req && mem_we && mem_ack) writes++;
    step();
    mem_ack = 1'b0; WE = 1'b0;
    settle();
    chk("wr_after_req", mem_req, 0);
    chk("wr_count", 32'(writes), 1);
    bmem[addr >> 2] = data;
    $display("write      A=0x%08h WD=0x%08h ack_delay=%0d", addr, data, delay);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    preload(32'h100, 32'hA0);
    preload(32'h500, 32'hB0);
    preload(32'h300, 32'hC0);
    preload(32'h2000, 32'hD0);
    reset = 1'b1; A = '0; WD = '0; WE = 1'b0; RE = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    reset = 1'b0;
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    $display("reset      stall=%0d mem_req=%0d mem_addr=0x%08h", stall, mem_req, mem_addr);

    read_miss(32'h100);
    read_hit(32'h108, 32'hA2);

    write(32'h104, 32'hDEADBEEF, 3);
    read_hit(32'h104, 32'hDEADBEEF);

    write(32'h2000, 32'h12345678, 0);
    read_miss(32'h2000);

    read_hit(32'h100, 32'hA0);
    read_miss(32'h500);
    read_miss(32'h100);
    read_hit(32'h104, 32'hDEADBEEF);

    // Stray ack while idle must be ignored; RD still shows the cached word.
    step();
    RE = 1'b0; WE = 1'b0; A = 32'h108; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("idle_ack_req", mem_req, 0);
    chk("idle_ack_stall", stall, 0);
    chk("idle_rd", RD, 32'hA2);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    settle();
    chk("idle_ack_after", mem_req, 0);
    $display("idle ack   mem_req=%0d RD=0x%08h", mem_req, RD);
    read_hit(32'h108, 32'hA2);

    // Abort a refill of 0x300 after its second ack.
    step();
    RE = 1'b1; WE = 1'b0; A = 32'h300;
    settle();
    chk("abort_miss_stall", stall, 1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hC0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'hC1;
    settle();
    chk("abort_addr2", mem_addr, 32'h304);
    step();
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    settle();
    chk("abort_pre_addr", mem_addr, 32'h308);
    step();
    reset = 1'b0; RE = 1'b0;
    settle();
    chk("abort_mem_req", mem_req, 0);
    chk("abort_stall", stall, 0);
    $display("reset mid-refill  mem_req=%0d", mem_req);
    read_miss(32'h300);
    read_hit(32'h30C, 32'hC3);
    read_miss(32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
